ls_pilot_estimator: RTL
=======================

Name: ls_pilot_estimator

Overview:
- Producer side of the channel-estimation interpolator: computes least-squares channel estimates at NRS pilot REs and delivers them in groups of four as E1..E4 (real and imaginary).
- Each pilot estimate is the received sample multiplied by the conjugate of the known QPSK pilot, with |p|^2 = 2 left unnormalised.
- A collect buffer and an output buffer let a new group accumulate while the previous group waits for the interpolation controller.

Parameters:
- Y_WIDTH, 16, signed width of each received sample component.
- E_WIDTH, 17, signed width of each estimate component; must equal Y_WIDTH+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle pulse; discards any partial group.
- pilot_valid  in  1  y_r/y_i/p_r/p_i valid this cycle.
- y_r, y_i  in  Y_WIDTH  received pilot RE, signed.
- p_r, p_i  in  1  known pilot sign bits; 0 = +1, 1 = -1.
- est_ready  in  1  consumer accepts the presented group.
- est_valid  out  1  E1..E4 hold a complete group.
- E1_r, E2_r, E3_r, E4_r  out  E_WIDTH  real estimates in pilot arrival order.
- E1_i, E2_i, E3_i, E4_i  out  E_WIDTH  imaginary estimates.
- overflow  out  1  one-cycle pulse when a pilot is dropped.

Behaviour:
- Reset (asynchronous) clears all E outputs, est_valid, overflow, the slot index, the collect buffer and the pending flag to 0.
- Per-pilot arithmetic (combinational, then written into the buffer):
  - a = p_r ? -1 : +1; b = p_i ? -1 : +1.
  - E_r = a*y_r + b*y_i; E_i = a*y_i - b*y_r.
  - Operands are sign-extended to E_WIDTH+1, summed, then saturated to [-2^(E_WIDTH-1), 2^(E_WIDTH-1)-1].
  - Only +65536 can saturate at the defaults (e.g. y_r = y_i = -32768 with a = b = -1); it maps to 65535.
- Collect (accepted = pilot_valid and not pending):
  - Accepted pilot writes slot idx (0..3); idx increments and wraps 3 -> 0.
  - The 4th accepted pilot completes the group.
- Transfer to output:
  - On the completing edge, if est_valid = 0 or (est_valid and est_ready), load the outputs with slots 0..2 plus the 4th result bypassed; est_valid = 1 from the next cycle. Latency is 1 cycle from the 4th pilot.
  - Otherwise set pending = 1; the collect buffer is frozen.
  - While pending, on the first edge with est_ready = 1 the outputs load from the collect buffer, est_valid stays 1, and pending clears.
- Handshake:
  - Outputs are stable while est_valid and not est_ready.
  - est_valid drops after a handshake edge unless a group loads on that same edge.
- Overflow:
  - pilot_valid while pending -> pilot dropped, idx unchanged, overflow = 1 for one cycle.
  - A pilot arriving on the same edge pending clears is still dropped.
- frame_start:
  - Forces idx to 0 and discards the partial group.
  - Does not affect a pending full group, the output buffer or est_valid.
  - frame_start together with pilot_valid (not pending): the pilot is written to slot 0 and idx becomes 1.
- Reset asserted mid-group or mid-handshake: everything clears immediately; no group survives reset.

Test Plan:
- Reset values: assert rst mid-stream -> est_valid = 0, all E = 0 and overflow = 0 while rst is high and the cycle after release.
- Arithmetic check: est_ready = 1; four pilots y = (100, 50) with (p_r, p_i) = (0,0), (1,0), (0,1), (1,1) -> E1 = (150, -50), E2 = (-50, -150), E3 = (50, 150), E4 = (-150, 50); est_valid rises 1 cycle after the 4th pilot.
- Saturation: y = (-32768, -32768), p = (1,1) -> E_r = 65535, E_i = 0; y = (32767, 32767), p = (0,0) -> E_r = 65534, E_i = 0.
- Backpressure: est_ready = 0; send 8 pilots (values 1..8 in y_r, p = 0) then a 9th -> E1..E4_r = 1..4 held; pending set; 9th pilot dropped with a one-cycle overflow pulse. Raise est_ready for 1 cycle -> E1..E4_r = 5..8 next cycle with est_valid still 1; a second ready -> est_valid = 0.
- frame_start: send 2 pilots, then frame_start with pilot_valid (y_r = 9), then 3 more pilots (10, 11, 12) -> group E1..E4_r = 9, 10, 11, 12; the first two pilots never appear.
- Streaming: est_ready held at 1; 16 back-to-back pilots -> 4 groups, each est_valid for exactly 1 cycle, no overflow.

Source files
------------

// File: rtl/ls_pilot_estimator.sv
// Least-squares channel estimates at NRS pilot REs, delivered to the
// interpolation controller in groups of four through a collect/output double buffer.
module ls_pilot_estimator #(
  parameter int Y_WIDTH = 16,
  parameter int E_WIDTH = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pilot_valid,
  input  logic signed [Y_WIDTH-1:0] y_r,
  input  logic signed [Y_WIDTH-1:0] y_i,
  input  logic                      p_r,
  input  logic                      p_i,
  input  logic                      est_ready,
  output logic                      est_valid,
  output logic signed [E_WIDTH-1:0] E1_r,
  output logic signed [E_WIDTH-1:0] E2_r,
  output logic signed [E_WIDTH-1:0] E3_r,
  output logic signed [E_WIDTH-1:0] E4_r,
  output logic signed [E_WIDTH-1:0] E1_i,
  output logic signed [E_WIDTH-1:0] E2_i,
  output logic signed [E_WIDTH-1:0] E3_i,
  output logic signed [E_WIDTH-1:0] E4_i,
  output logic                      overflow
);

  localparam int S_WIDTH = E_WIDTH + 1;
  localparam logic signed [S_WIDTH-1:0] MAX_E = {2'b00, {(E_WIDTH-1){1'b1}}};
  localparam logic signed [S_WIDTH-1:0] MIN_E = {2'b11, {(E_WIDTH-1){1'b0}}};

  logic signed [S_WIDTH-1:0] yr_ext, yi_ext, a_yr, a_yi, b_yr, b_yi, sum_r, sum_i;
  logic signed [E_WIDTH-1:0] est_r, est_i;
  logic signed [E_WIDTH-1:0] col_r [4];
  logic signed [E_WIDTH-1:0] col_i [4];
  logic [1:0] idx, slot;
  logic       pending, accepted, complete, can_load;

  function automatic logic signed [E_WIDTH-1:0] saturate(input logic signed [S_WIDTH-1:0] s);
    if (s > MAX_E)      return MAX_E[E_WIDTH-1:0];
    else if (s < MIN_E) return MIN_E[E_WIDTH-1:0];
    else                return s[E_WIDTH-1:0];
  endfunction

  // y * conj(p) with |p|^2 = 2 left in; only the all-negative corner can exceed range
  always_comb begin
    yr_ext = {{(S_WIDTH-Y_WIDTH){y_r[Y_WIDTH-1]}}, y_r};
    yi_ext = {{(S_WIDTH-Y_WIDTH){y_i[Y_WIDTH-1]}}, y_i};
    a_yr   = p_r ? -yr_ext : yr_ext;
    a_yi   = p_r ? -yi_ext : yi_ext;
    b_yr   = p_i ? -yr_ext : yr_ext;
    b_yi   = p_i ? -yi_ext : yi_ext;
    sum_r  = a_yr + b_yi;
    sum_i  = a_yi - b_yr;
    est_r  = saturate(sum_r);
    est_i  = saturate(sum_i);
  end

  assign accepted = pilot_valid && !pending;
  assign slot     = frame_start ? 2'd0 : idx;
  assign complete = accepted && (slot == 2'd3);
  assign can_load = !est_valid || est_ready;

  // The fourth pilot bypasses the collect buffer so the group appears one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      pending   <= 1'b0;
      est_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        col_r[k] <= '0;
        col_i[k] <= '0;
      end
      E1_r <= '0; E2_r <= '0; E3_r <= '0; E4_r <= '0;
      E1_i <= '0; E2_i <= '0; E3_i <= '0; E4_i <= '0;
    end else begin
      overflow <= pilot_valid && pending;
      if (accepted) begin
        col_r[slot] <= est_r;
        col_i[slot] <= est_i;
        idx         <= slot + 2'd1;
      end else if (frame_start) begin
        idx <= '0;
      end
      if (complete && can_load) begin
        E1_r <= col_r[0]; E2_r <= col_r[1]; E3_r <= col_r[2]; E4_r <= est_r;
        E1_i <= col_i[0]; E2_i <= col_i[1]; E3_i <= col_i[2]; E4_i <= est_i;
        est_valid <= 1'b1;
      end else if (complete) begin
        pending <= 1'b1;
      end else if (pending && est_ready) begin
        E1_r <= col_r[0]; E2_r <= col_r[1]; E3_r <= col_r[2]; E4_r <= col_r[3];
        E1_i <= col_i[0]; E2_i <= col_i[1]; E3_i <= col_i[2]; E4_i <= col_i[3];
        pending <= 1'b0;
      end else if (est_valid && est_ready) begin
        est_valid <= 1'b0;
      end
    end
  end

endmodule
